sc_button_debouncer: RTL and testbench
======================================

SC_BUTTON_DEBOUNCER -- requirements
Module: SC_BUTTON_DEBOUNCER

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16'd50000 (1 ms at 50 MHz), stable-input cycles required before output changes.
REQ-002 Parameter REPEAT_DELAY, default 24'd12500000 (250 ms), hold time before first auto-repeat.
REQ-003 Parameter REPEAT_PERIOD, default 24'd5000000 (100 ms), interval between later auto-repeats.
REQ-004 SC_BUTTON_DEBOUNCER_CLOCK_50  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-005 SC_BUTTON_DEBOUNCER_RESET_InLow  input  1  asynchronous active-low reset.
REQ-006 SC_BUTTON_DEBOUNCER_startButton_InLow  input  1  raw asynchronous start button, 0 = pressed.
REQ-007 SC_BUTTON_DEBOUNCER_leftButton_InLow  input  1  raw asynchronous left button, 0 = pressed.
REQ-008 SC_BUTTON_DEBOUNCER_rightButton_InLow  input  1  raw asynchronous right button, 0 = pressed.
REQ-009 SC_BUTTON_DEBOUNCER_startButton_OutLow  output  1  clean start level, 0 = pressed; feeds point state machine start input.
REQ-010 SC_BUTTON_DEBOUNCER_leftButton_OutLow  output  1  clean left level, 0 = pressed; feeds point state machine left input.
REQ-011 SC_BUTTON_DEBOUNCER_rightButton_OutLow  output  1  clean right level, 0 = pressed; feeds point state machine right input.

Function
REQ-012 Three identical, fully independent channels; no priority between buttons (downstream FSM resolves priority).
REQ-013 Each raw input SHALL pass a 2-flop synchronizer before any other logic; synchronizer flops reset to 1.
REQ-014 Each channel SHALL run a 4-state FSM: IDLE (out 1), CNT_LOW (out 1), PRESSED (out 0), CNT_HIGH (out 0); outputs registered.
REQ-015 IDLE: sync==0 -> CNT_LOW, debounce counter cleared to 0; else stay.
REQ-016 CNT_LOW: sync==1 -> IDLE (bounce rejected); counter==DEBOUNCE_CYCLES-1 -> PRESSED; else counter+1.
REQ-017 PRESSED: sync==1 -> CNT_HIGH, counter cleared; else stay.
REQ-018 CNT_HIGH: sync==0 -> PRESSED (bounce rejected, no output change); counter==DEBOUNCE_CYCLES-1 -> IDLE; else counter+1.
REQ-019 Latency: input held low from cycle 0 -> output low after edge DEBOUNCE_CYCLES+3; release symmetric.
REQ-020 Any glitch shorter than DEBOUNCE_CYCLES SHALL produce no output change.
REQ-021 Debounce counter 16 bits, repeat counter 24 bits, saturating never required (counters cleared on every state entry).
REQ-022 Simultaneous presses SHALL be debounced independently; each output follows its own channel only.

Reset
REQ-023 Reset low SHALL asynchronously force all FSMs to IDLE, all counters to 0, synchronizer flops to 1, all three outputs to 1.
REQ-024 Reset asserted mid-count or mid-press SHALL discard progress; after release a held button needs a full DEBOUNCE_CYCLES+3 again.

Configuration
REQ-025 Macro SC_BUTTON_DEBOUNCER_AUTOREPEAT_EN SHALL enable auto-repeat on left and right channels only; start never repeats.
REQ-026 With macro: in PRESSED, repeat counter counts; after REPEAT_DELAY cycles output SHALL go 1 for exactly 2 cycles then back to 0, then same 2-cycle gap every REPEAT_PERIOD cycles while held; repeat counter cleared on leaving PRESSED.
REQ-027 2-cycle gap guarantees downstream FSM passes its release-check state back to its idle-check state and registers a new press.
REQ-028 Without macro: repeat counter and gap logic absent; output stays 0 for entire hold.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=10)
REQ-029 Left held low from cycle 0 -> leftButton_OutLow 1 through edge 6, 0 after edge 7; other outputs stay 1.
REQ-030 Right input low 3 cycles then high, repeated 5 times -> rightButton_OutLow never leaves 1.
REQ-031 Start pressed, output low, then 2-cycle high glitch -> startButton_OutLow stays 0; clean release -> 1 after 7 cycles.
REQ-032 Left held 12 cycles, reset low at cycle 9 for 1 cycle -> outputs 1 immediately on reset; left low again 7 cycles after reset release.
REQ-033 Macro on, left held 60 cycles -> output 0 at 7, high-gap 2 cycles at 27, 37, 47, 57; start held 60 cycles -> no gaps.
REQ-034 All three pressed same cycle -> all three outputs fall on same edge (7); macro off, 60-cycle hold -> no gaps.

Source files
------------

// File: rtl/sc_button_debouncer.sv
// sc_button_debouncer
// Debounces the three active-low push buttons (start, left, right) feeding the
// point state machine. Each button runs its own channel: a 2-flop synchronizer
// followed by a 4-state debounce FSM with a registered, active-low output.
//
// Build option: define SC_BUTTON_DEBOUNCER_AUTOREPEAT_EN to give the left and
// right channels auto-repeat. While one of these buttons is held, its output
// pulses high for 2 cycles after REPEAT_DELAY cycles. It then pulses high again
// every REPEAT_PERIOD cycles. The start channel never repeats. With the macro
// undefined, the repeat logic is not built and a held button stays low.

module sc_button_debouncer_channel #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
`ifdef SC_BUTTON_DEBOUNCER_AUTOREPEAT_EN
    ,
    parameter logic [23:0] REPEAT_DELAY    = 24'd12500000,
    parameter logic [23:0] REPEAT_PERIOD   = 24'd5000000,
    parameter bit          REPEAT_EN       = 1'b0
`endif
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_raw_ni,
    output logic btn_clean_no
);

    // Debounce FSM encoding.
    localparam logic [1:0] ST_IDLE     = 2'd0;  // released, output 1
    localparam logic [1:0] ST_CNT_LOW  = 2'd1;  // qualifying a press, output 1
    localparam logic [1:0] ST_PRESSED  = 2'd2;  // pressed, output 0
    localparam logic [1:0] ST_CNT_HIGH = 2'd3;  // qualifying a release, output 0

    localparam logic [15:0] DEB_LAST = DEBOUNCE_CYCLES - 16'd1;

    logic        sync1_q;
    logic        sync2_q;
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        out_q;
    logic        out_d;
    logic        gap_active_d;

    // Bring the raw button into the clock domain. Idle level is 1 (released).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_raw_ni;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM next state. The counter is cleared on every state entry, so
    // it never needs to saturate.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!sync2_q) begin
                    state_d = ST_CNT_LOW;
                    cnt_d   = 16'd0;
                end
            end
            ST_CNT_LOW: begin
                if (sync2_q) begin
                    // A bounce ends the press attempt.
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_PRESSED: begin
                if (sync2_q) begin
                    state_d = ST_CNT_HIGH;
                    cnt_d   = 16'd0;
                end
            end
            ST_CNT_HIGH: begin
                if (!sync2_q) begin
                    // A bounce during release: the output stays pressed.
                    state_d = ST_PRESSED;
                    cnt_d   = 16'd0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

`ifdef SC_BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam logic [23:0] REP_FIRST_LAST  = REPEAT_DELAY - 24'd1;
    localparam logic [23:0] REP_PERIOD_LAST = REPEAT_PERIOD - 24'd1;

    logic [23:0] rep_cnt_q;
    logic [23:0] rep_cnt_d;
    logic        rep_first_done_q;
    logic        rep_first_done_d;
    logic [1:0]  gap_q;
    logic [1:0]  gap_d;

    // Auto-repeat timing. The counter runs only while the FSM stays in PRESSED.
    // Each expiry restarts it and opens a 2-cycle high gap on the output. This
    // gap lets the downstream FSM see a release and then register a new press.
    always_comb begin
        rep_cnt_d        = rep_cnt_q;
        rep_first_done_d = rep_first_done_q;
        gap_d            = (gap_q != 2'd0) ? gap_q - 2'd1 : 2'd0;
        if (REPEAT_EN && (state_q == ST_PRESSED) && (state_d == ST_PRESSED)) begin
            rep_cnt_d = rep_cnt_q + 24'd1;
            if ((!rep_first_done_q && (rep_cnt_q == REP_FIRST_LAST)) ||
                ( rep_first_done_q && (rep_cnt_q == REP_PERIOD_LAST))) begin
                rep_cnt_d        = 24'd0;
                rep_first_done_d = 1'b1;
                gap_d            = 2'd2;
            end
        end else begin
            rep_cnt_d        = 24'd0;
            rep_first_done_d = 1'b0;
            gap_d            = 2'd0;
        end
    end

    // Auto-repeat state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rep_cnt_q        <= 24'd0;
            rep_first_done_q <= 1'b0;
            gap_q            <= 2'd0;
        end else begin
            rep_cnt_q        <= rep_cnt_d;
            rep_first_done_q <= rep_first_done_d;
            gap_q            <= gap_d;
        end
    end

    assign gap_active_d = (gap_d != 2'd0);
`else
    assign gap_active_d = 1'b0;
`endif

    // Output level follows the next state. It is registered together with the
    // state so that it changes on the same edge as the state.
    always_comb begin
        out_d = ((state_d == ST_IDLE) || (state_d == ST_CNT_LOW)) | gap_active_d;
    end

    // FSM, debounce counter and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            out_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign btn_clean_no = out_q;

endmodule

module sc_button_debouncer #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] REPEAT_DELAY    = 24'd12500000,
    parameter logic [23:0] REPEAT_PERIOD   = 24'd5000000
) (
    input  logic SC_BUTTON_DEBOUNCER_CLOCK_50,
    input  logic SC_BUTTON_DEBOUNCER_RESET_InLow,
    input  logic SC_BUTTON_DEBOUNCER_startButton_InLow,
    input  logic SC_BUTTON_DEBOUNCER_leftButton_InLow,
    input  logic SC_BUTTON_DEBOUNCER_rightButton_InLow,
    output logic SC_BUTTON_DEBOUNCER_startButton_OutLow,
    output logic SC_BUTTON_DEBOUNCER_leftButton_OutLow,
    output logic SC_BUTTON_DEBOUNCER_rightButton_OutLow
);

    // Channel index: 0 = start, 1 = left, 2 = right. Only left and right repeat.
    localparam logic [2:0] REPEAT_MASK = 3'b110;

    logic [2:0] raw_n;
    logic [2:0] clean_n;

    assign raw_n = {SC_BUTTON_DEBOUNCER_rightButton_InLow,
                    SC_BUTTON_DEBOUNCER_leftButton_InLow,
                    SC_BUTTON_DEBOUNCER_startButton_InLow};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            sc_button_debouncer_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef SC_BUTTON_DEBOUNCER_AUTOREPEAT_EN
                ,
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD),
                .REPEAT_EN       (REPEAT_MASK[gi])
`endif
            ) u_chan (
                .clk_i        (SC_BUTTON_DEBOUNCER_CLOCK_50),
                .rst_ni       (SC_BUTTON_DEBOUNCER_RESET_InLow),
                .btn_raw_ni   (raw_n[gi]),
                .btn_clean_no (clean_n[gi])
            );
        end
    endgenerate

`ifndef SC_BUTTON_DEBOUNCER_AUTOREPEAT_EN
    // Without auto-repeat, the repeat settings have no effect on any channel.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD, REPEAT_MASK};
`endif

    assign SC_BUTTON_DEBOUNCER_startButton_OutLow = clean_n[0];
    assign SC_BUTTON_DEBOUNCER_leftButton_OutLow  = clean_n[1];
    assign SC_BUTTON_DEBOUNCER_rightButton_OutLow = clean_n[2];

endmodule

// File: tb/tb_sc_button_debouncer.sv
// Directed bench for sc_button_debouncer with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=10. Edge numbers count rising edges after
// the stimulus change. Outputs are sampled 1 ns after each rising edge.
module tb_sc_button_debouncer;

    localparam int DEB  = 4;
    localparam int RDLY = 20;
    localparam int RPER = 10;
    localparam int LAT  = DEB + 3;

`ifdef SC_BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic start_n;
    logic left_n;
    logic right_n;
    logic start_o;
    logic left_o;
    logic right_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sc_button_debouncer #(
        .DEBOUNCE_CYCLES (16'(DEB)),
        .REPEAT_DELAY    (24'(RDLY)),
        .REPEAT_PERIOD   (24'(RPER))
    ) dut (
        .SC_BUTTON_DEBOUNCER_CLOCK_50          (clk),
        .SC_BUTTON_DEBOUNCER_RESET_InLow       (rst_n),
        .SC_BUTTON_DEBOUNCER_startButton_InLow (start_n),
        .SC_BUTTON_DEBOUNCER_leftButton_InLow  (left_n),
        .SC_BUTTON_DEBOUNCER_rightButton_InLow (right_n),
        .SC_BUTTON_DEBOUNCER_startButton_OutLow(start_o),
        .SC_BUTTON_DEBOUNCER_leftButton_OutLow (left_o),
        .SC_BUTTON_DEBOUNCER_rightButton_OutLow(right_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected output e edges after a press starts, while the button stays held.
    function automatic logic held_exp(input int e, input bit rep);
        if (e < LAT) return 1'b1;
        if (rep && (e >= LAT + RDLY) && (((e - LAT - RDLY) % RPER) < 2)) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        rst_n   = 1'b0;
        start_n = 1'b1;
        left_n  = 1'b1;
        right_n = 1'b1;

        // Reset state.
        repeat (3) tick();
        check_val("rst_start", start_o, 1);
        check_val("rst_left",  left_o,  1);
        check_val("rst_right", right_o, 1);
        rst_n = 1'b1;
        repeat (2) tick();
        check_val("idle_left", left_o, 1);
        $display("[TB] reset state checked");

        // Left held: low exactly after edge 7; others untouched.
        left_n = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_val($sformatf("left_press_e%0d", e), left_o, held_exp(e, 1'b0));
        end
        check_val("left_press_start", start_o, 1);
        check_val("left_press_right", right_o, 1);
        left_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_val($sformatf("left_release_e%0d", e), left_o, (e >= LAT) ? 1 : 0);
        end
        $display("[TB] left press/release latency checked");

        // Right glitches of 3 low cycles are rejected.
        for (int g = 0; g < 5; g++) begin
            right_n = 1'b0;
            for (int c = 0; c < 3; c++) begin
                tick();
                check_val($sformatf("right_glitch_g%0d_lo%0d", g, c), right_o, 1);
            end
            right_n = 1'b1;
            for (int c = 0; c < 3; c++) begin
                tick();
                check_val($sformatf("right_glitch_g%0d_hi%0d", g, c), right_o, 1);
            end
        end
        repeat (6) tick();
        check_val("right_glitch_end", right_o, 1);
        $display("[TB] right glitch rejection checked");

        // Start press, 2-cycle release glitch ignored, then clean release.
        start_n = 1'b0;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            check_val($sformatf("start_press_e%0d", e), start_o, held_exp(e, 1'b0));
        end
        start_n = 1'b1;
        repeat (2) tick();
        start_n = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_val($sformatf("start_glitch_c%0d", c), start_o, 0);
        end
        start_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check_val($sformatf("start_release_e%0d", e), start_o, (e >= LAT) ? 1 : 0);
        end
        $display("[TB] start glitch and release checked");

        // Reset during a held press discards progress.
        left_n = 1'b0;
        repeat (9) tick();
        check_val("rst_mid_left_before", left_o, 0);
        rst_n = 1'b0;
        #1;
        check_val("rst_async_left",  left_o,  1);
        check_val("rst_async_start", start_o, 1);
        check_val("rst_async_right", right_o, 1);
        tick();
        check_val("rst_hold_left", left_o, 1);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check_val($sformatf("rst_repress_e%0d", e), left_o, held_exp(e, 1'b0));
        end
        left_n = 1'b1;
        repeat (10) tick();
        check_val("rst_release_left", left_o, 1);
        $display("[TB] reset mid-press checked");

        // All three held together for 60 cycles; repeat gaps only on left/right.
        start_n = 1'b0;
        left_n  = 1'b0;
        right_n = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            tick();
            check_val($sformatf("all_start_e%0d", e), start_o, held_exp(e, 1'b0));
            check_val($sformatf("all_left_e%0d",  e), left_o,  held_exp(e, REP_ON));
            check_val($sformatf("all_right_e%0d", e), right_o, held_exp(e, REP_ON));
        end
        start_n = 1'b1;
        left_n  = 1'b1;
        right_n = 1'b1;
        repeat (10) tick();
        check_val("all_rel_start", start_o, 1);
        check_val("all_rel_left",  left_o,  1);
        check_val("all_rel_right", right_o, 1);
        $display("[TB] simultaneous 60-cycle hold checked (repeat=%0d)", REP_ON);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
